// File: rtl/adder_pipe_if.sv
// adder_pipe streaming bus: operation request side and result side,
// each with its own valid/ready handshake.
interface adder_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             sub;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, operand_a, operand_b,
    output sub, carry_in, out_ready,
    input  in_ready, out_valid, sum,
    input  carry_out, overflow
  );

  modport slave (
    input  in_valid, operand_a, operand_b,
    input  sub, carry_in, out_ready,
    output in_ready, out_valid, sum,
    output carry_out, overflow
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: the carry chain is cut into STAGES chunks,
// one chunk resolved per register stage, whole pipe stalls together.
module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  adder_pipe_if.slave bus
);

  localparam int C = WIDTH / STAGES;

  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t st_q [STAGES];
  stage_t st_n [STAGES];
  stage_t src;
  stage_t lst;
  logic   ov_q;
  logic   ov_n;
  logic   advance;

  function automatic stage_t chunk_add(
    input stage_t x,
    input int     k
  );
    stage_t     r;
    logic [C:0] p;
    p = {1'b0, x.a[k*C +: C]}
      + {1'b0, x.b[k*C +: C]}
      + {{C{1'b0}}, x.c};
    r = x;
    r.s[k*C +: C] = p[C-1:0];
    r.c = p[C];
    return r;
  endfunction

  always_comb begin
    src       = '0;
    src.v     = bus.in_valid;
    src.a     = bus.operand_a;
    src.b     = bus.operand_b ^ {WIDTH{bus.sub}};
    src.c     = bus.sub | bus.carry_in;
    st_n[0]   = chunk_add(src, 0);
    for (int k = 1; k < STAGES; k++) begin
      st_n[k] = chunk_add(st_q[k-1], k);
    end
    // overflow only needs the operand MSBs that rode along with the data
    lst  = st_n[STAGES-1];
    ov_n = (lst.a[WIDTH-1] == lst.b[WIDTH-1])
        && (lst.s[WIDTH-1] != lst.a[WIDTH-1]);
  end

  assign advance       = !st_q[STAGES-1].v || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = st_q[STAGES-1].v;
  assign bus.sum       = st_q[STAGES-1].s;
  assign bus.carry_out = st_q[STAGES-1].c;
  assign bus.overflow  = ov_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
      ov_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= st_n[k];
      end
      ov_q <= ov_n;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe (WIDTH=8, STAGES=2): arithmetic,
// latency, backpressure, mid-stream reset and a random stream.
module tb_adder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  adder_pipe_if #(.WIDTH(8)) bus ();

  adder_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       s,
    input  logic       ci,
    output int         lat,
    output logic [7:0] sm,
    output logic       co,
    output logic       ov
  );
    bus.in_valid  = 1'b1;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.sub       = s;
    bus.carry_in  = ci;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      step();
      lat++;
    end
    sm = bus.sum;
    co = bus.carry_out;
    ov = bus.overflow;
    step();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.sub       = 1'b0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.sum !== 8'd0) begin
      errors++;
      $display("FAIL reset_sum got=%0d exp=0", bus.sum);
    end
    checks++;
    if (bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b%b exp=00",
               bus.carry_out, bus.overflow);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    int         lat;
    logic [7:0] sm;
    logic       co, ov;
    issue(8'd10, 8'd20, 1'b0, 1'b0, lat, sm, co, ov);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL add_latency got=%0d exp=2", lat);
    end
    checks++;
    if (sm !== 8'd30) begin
      errors++;
      $display("FAIL add_sum got=%0d exp=30", sm);
    end
    checks++;
    if (co !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL add_flags got=%b%b exp=00", co, ov);
    end
  endtask

  task automatic test_carry();
    logic [7:0] ta [3] = '{8'd200, 8'd255, 8'd100};
    logic [7:0] tb [3] = '{8'd100, 8'd0,   8'd50};
    logic       tc [3] = '{1'b0,   1'b1,   1'b0};
    logic [7:0] es [3] = '{8'd44,  8'd0,   8'd150};
    logic       ec [3] = '{1'b1,   1'b1,   1'b0};
    logic       eo [3] = '{1'b0,   1'b0,   1'b1};
    int         lat;
    logic [7:0] sm;
    logic       co, ov;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb[i], 1'b0, tc[i], lat, sm, co, ov);
      checks++;
      if (sm !== es[i]) begin
        errors++;
        $display("FAIL carry_sum[%0d] got=%0d exp=%0d", i, sm, es[i]);
      end
      checks++;
      if (co !== ec[i]) begin
        errors++;
        $display("FAIL carry_cout[%0d] got=%b exp=%b", i, co, ec[i]);
      end
      checks++;
      if (ov !== eo[i]) begin
        errors++;
        $display("FAIL carry_ovf[%0d] got=%b exp=%b", i, ov, eo[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [7:0] ta [2] = '{8'd15,  8'd128};
    logic [7:0] tb [2] = '{8'd25,  8'd1};
    logic [7:0] es [2] = '{8'd246, 8'd127};
    logic       ec [2] = '{1'b0,   1'b1};
    logic       eo [2] = '{1'b0,   1'b1};
    int         lat;
    logic [7:0] sm;
    logic       co, ov;
    for (int i = 0; i < 2; i++) begin
      issue(ta[i], tb[i], 1'b1, 1'b1, lat, sm, co, ov);
      checks++;
      if (sm !== es[i]) begin
        errors++;
        $display("FAIL sub_sum[%0d] got=%0d exp=%0d", i, sm, es[i]);
      end
      checks++;
      if (co !== ec[i]) begin
        errors++;
        $display("FAIL sub_cout[%0d] got=%b exp=%b", i, co, ec[i]);
      end
      checks++;
      if (ov !== eo[i]) begin
        errors++;
        $display("FAIL sub_ovf[%0d] got=%b exp=%b", i, ov, eo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
    int   nin = 0;
    int   nout = 0;
    int   stall = 0;
    int   ghosts = 0;
    logic seen = 1'b0;
    logic acc;
    bus.sub      = 1'b0;
    bus.carry_in = 1'b0;
    for (int cyc = 0; cyc < 30 && nout < 4; cyc++) begin
      bus.in_valid  = (nin < 4);
      bus.operand_a = 8'(nin + 1);
      bus.operand_b = 8'(nin + 1);
      if (bus.out_valid && !seen) begin
        seen  = 1'b1;
        stall = 3;
      end
      bus.out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_stall_ready got=%b exp=0", bus.in_ready);
        end
        checks++;
        if (bus.sum !== 8'd2 || bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_hold got=%0d/%b exp=2/1",
                   bus.sum, bus.out_valid);
        end
      end
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.sum !== exp[nout]) begin
          errors++;
          $display("FAIL b2b_order[%0d] got=%0d exp=%0d",
                   nout, bus.sum, exp[nout]);
        end
        nout++;
      end
      step();
      if (acc) nin++;
      if (stall > 0) stall--;
    end
    checks++;
    if (nout !== 4) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=4", nout);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid) ghosts++;
      step();
    end
    checks++;
    if (ghosts !== 0) begin
      errors++;
      $display("FAIL b2b_repeat got=%0d exp=0", ghosts);
    end
  endtask

  task automatic test_reset_mid();
    int ghosts = 0;
    bus.sub       = 1'b0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.operand_a = 8'd50;
    bus.operand_b = 8'd1;
    step();
    bus.operand_a = 8'd60;
    step();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_fill got=%b exp=1", bus.out_valid);
    end
    bus.operand_a = 8'd70;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_clear got=%b/%0d exp=0/0",
               bus.out_valid, bus.sum);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got=%b exp=1", bus.in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.out_valid) ghosts++;
    end
    checks++;
    if (ghosts !== 0) begin
      errors++;
      $display("FAIL rstmid_ghost got=%0d exp=0", ghosts);
    end
  endtask

  task automatic test_stream();
    logic [9:0] q [$];
    logic [9:0] e;
    logic [7:0] a, b, bp;
    logic       s, ci, c0;
    logic [8:0] r;
    int         nin = 0;
    int         nout = 0;
    int         bubbles = 0;
    a  = 8'($urandom_range(255));
    b  = 8'($urandom_range(255));
    s  = 1'($urandom_range(1));
    ci = 1'($urandom_range(1));
    for (int cyc = 0; cyc < 3000 && nout < 256; cyc++) begin
      bus.in_valid  = (nin < 256);
      bus.operand_a = a;
      bus.operand_b = b;
      bus.sub       = s;
      bus.carry_in  = ci;
      bus.out_ready = ($urandom_range(3) != 0);
      #1;
      if (nout > 0 && !bus.out_valid) bubbles++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra[%0d] got=%0d exp=none",
                   nout, bus.sum);
        end else begin
          e = q.pop_front();
          if ({bus.carry_out, bus.overflow, bus.sum} !== e) begin
            errors++;
            $display("FAIL stream[%0d] got=%b%b/%0d exp=%b%b/%0d",
                     nout, bus.carry_out, bus.overflow, bus.sum,
                     e[9], e[8], e[7:0]);
          end
        end
        nout++;
      end
      if (bus.in_valid && bus.in_ready) begin
        bp = s ? ~b : b;
        c0 = s ? 1'b1 : ci;
        r  = {1'b0, a} + {1'b0, bp} + {8'd0, c0};
        q.push_back({r[8],
                     (a[7] == bp[7]) && (r[7] != a[7]),
                     r[7:0]});
        nin++;
        a  = 8'($urandom_range(255));
        b  = 8'($urandom_range(255));
        s  = 1'($urandom_range(1));
        ci = 1'($urandom_range(1));
      end
      step();
    end
    checks++;
    if (nout !== 256) begin
      errors++;
      $display("FAIL stream_count got=%0d exp=256", nout);
    end
    checks++;
    if (bubbles !== 0) begin
      errors++;
      $display("FAIL stream_bubbles got=%0d exp=0", bubbles);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
